// File: rtl/billiard_pkg.sv
// Shared types and constants for the billiard table scoring logic.
package billiard_pkg;

  typedef enum logic [1:0] {IDLE, CHECK, EVAL, SCORED} state_t;

  localparam logic [2:0] POCKET_NONE = 3'd7;
  localparam int         NUM_POCKETS = 6;
  localparam int         COORD_W     = 11;

endpackage

// File: rtl/pocket_dist_cmp.sv
// Combinational squared-distance test: hit when (cx-px)^2 + (cy-py)^2 < r_sq.
module pocket_dist_cmp (
  input  logic [11:0] centre_x,
  input  logic [11:0] centre_y,
  input  logic [11:0] pocket_x,
  input  logic [11:0] pocket_y,
  input  logic [24:0] r_sq,
  output logic        hit
);

  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic signed [23:0] dx_w;
  logic signed [23:0] dy_w;
  logic signed [23:0] dx_sq;
  logic signed [23:0] dy_sq;
  logic        [24:0] dist_sq;

  // Widen before squaring so the full signed product is kept; squares are never negative.
  always_comb begin
    dx      = centre_x - pocket_x;
    dy      = centre_y - pocket_y;
    dx_w    = 24'(dx);
    dy_w    = 24'(dy);
    dx_sq   = dx_w * dx_w;
    dy_sq   = dy_w * dy_w;
    dist_sq = {1'b0, dx_sq} + {1'b0, dy_sq};
    hit     = dist_sq < r_sq;
  end

endmodule

// File: rtl/pocket_detector.sv
// Per-ball pocket detector: scans six pockets once per frame and latches a sticky score.
// Multi-frame dwell filtering is built only when POCKET_DWELL_FILTER_EN is defined.
module pocket_detector
  import billiard_pkg::*;
#(
  parameter int BALL_SIZE     = 16,
  parameter int TABLE_LEFT    = 32,
  parameter int TABLE_TOP     = 32,
  parameter int TABLE_RIGHT   = 607,
  parameter int TABLE_BOTTOM  = 447,
  parameter int POCKET_RADIUS = 12,
  parameter int DWELL_FRAMES  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] topLeftX,
  input  logic [COORD_W-1:0] topLeftY,
  input  logic               clear,
  output logic               ball_scored,
  output logic               scored_pulse,
  output logic [2:0]         pocket_id,
  output logic               busy
);

  localparam logic [11:0] HALF_BALL = 12'(BALL_SIZE / 2);
  localparam logic [11:0] LEFT_X    = 12'(TABLE_LEFT);
  localparam logic [11:0] MID_X     = 12'((TABLE_LEFT + TABLE_RIGHT) / 2);
  localparam logic [11:0] RIGHT_X   = 12'(TABLE_RIGHT);
  localparam logic [11:0] TOP_Y     = 12'(TABLE_TOP);
  localparam logic [11:0] BOTTOM_Y  = 12'(TABLE_BOTTOM);
  localparam logic [24:0] R_SQ      = 25'(POCKET_RADIUS * POCKET_RADIUS);
  localparam logic [2:0]  LAST_IDX  = 3'(NUM_POCKETS - 1);

  state_t      state, next_state;
  logic [11:0] centre_x, next_centre_x;
  logic [11:0] centre_y, next_centre_y;
  logic [2:0]  idx, next_idx;
  logic        hit_flag, next_hit_flag;
  logic [2:0]  hit_idx, next_hit_idx;
  logic        next_ball_scored;
  logic        next_scored_pulse;
  logic [2:0]  next_pocket_id;
  logic        score;
  logic [11:0] pocket_x;
  logic [11:0] pocket_y;
  logic        hit;

`ifdef POCKET_DWELL_FILTER_EN
  localparam logic [3:0] DWELL_TH = 4'(DWELL_FRAMES);
  logic [3:0] dwell_cnt, next_dwell_cnt;
  logic [2:0] last_pocket, next_last_pocket;
`else
  localparam int UNUSED_DWELL = DWELL_FRAMES;
`endif

  // Pocket geometry for the index currently being scanned: 0..2 top row, 3..5 bottom row.
  always_comb begin
    pocket_y = (idx < 3'd3) ? TOP_Y : BOTTOM_Y;
    case (idx)
      3'd0, 3'd3: pocket_x = LEFT_X;
      3'd1, 3'd4: pocket_x = MID_X;
      default:    pocket_x = RIGHT_X;
    endcase
  end

  pocket_dist_cmp u_cmp (
    .centre_x (centre_x),
    .centre_y (centre_y),
    .pocket_x (pocket_x),
    .pocket_y (pocket_y),
    .r_sq     (R_SQ),
    .hit      (hit)
  );

  always_comb begin
    next_state        = state;
    next_centre_x     = centre_x;
    next_centre_y     = centre_y;
    next_idx          = idx;
    next_hit_flag     = hit_flag;
    next_hit_idx      = hit_idx;
    next_ball_scored  = ball_scored;
    next_scored_pulse = 1'b0;
    next_pocket_id    = pocket_id;
    score             = 1'b0;
`ifdef POCKET_DWELL_FILTER_EN
    next_dwell_cnt    = dwell_cnt;
    next_last_pocket  = last_pocket;
`endif
    // clear re-arms from any state and swallows a coincident frame_tick.
    if (clear) begin
      next_state       = IDLE;
      next_centre_x    = '0;
      next_centre_y    = '0;
      next_idx         = '0;
      next_hit_flag    = 1'b0;
      next_hit_idx     = '0;
      next_ball_scored = 1'b0;
      next_pocket_id   = POCKET_NONE;
`ifdef POCKET_DWELL_FILTER_EN
      next_dwell_cnt   = '0;
      next_last_pocket = POCKET_NONE;
`endif
    end else begin
      case (state)
        IDLE: if (frame_tick) begin
          next_centre_x = {1'b0, topLeftX} + HALF_BALL;
          next_centre_y = {1'b0, topLeftY} + HALF_BALL;
          next_hit_flag = 1'b0;
          next_idx      = '0;
          next_state    = CHECK;
        end
        CHECK: begin
          if (hit && !hit_flag) begin
            next_hit_flag = 1'b1;
            next_hit_idx  = idx;
          end
          if (idx == LAST_IDX) next_state = EVAL;
          else                 next_idx   = idx + 3'd1;
        end
        EVAL: begin
`ifdef POCKET_DWELL_FILTER_EN
          if (hit_flag && hit_idx == last_pocket) begin
            next_dwell_cnt = (dwell_cnt == 4'd15) ? 4'd15 : dwell_cnt + 4'd1;
          end else if (hit_flag) begin
            next_dwell_cnt   = 4'd1;
            next_last_pocket = hit_idx;
          end else begin
            next_dwell_cnt   = '0;
            next_last_pocket = POCKET_NONE;
          end
          score = next_dwell_cnt >= DWELL_TH;
`else
          score = hit_flag;
`endif
          if (score) begin
            next_state        = SCORED;
            next_ball_scored  = 1'b1;
            next_pocket_id    = hit_idx;
            next_scored_pulse = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      centre_x     <= '0;
      centre_y     <= '0;
      idx          <= '0;
      hit_flag     <= 1'b0;
      hit_idx      <= '0;
      ball_scored  <= 1'b0;
      scored_pulse <= 1'b0;
      pocket_id    <= POCKET_NONE;
`ifdef POCKET_DWELL_FILTER_EN
      dwell_cnt    <= '0;
      last_pocket  <= POCKET_NONE;
`endif
    end else begin
      state        <= next_state;
      centre_x     <= next_centre_x;
      centre_y     <= next_centre_y;
      idx          <= next_idx;
      hit_flag     <= next_hit_flag;
      hit_idx      <= next_hit_idx;
      ball_scored  <= next_ball_scored;
      scored_pulse <= next_scored_pulse;
      pocket_id    <= next_pocket_id;
`ifdef POCKET_DWELL_FILTER_EN
      dwell_cnt    <= next_dwell_cnt;
      last_pocket  <= next_last_pocket;
`endif
    end
  end

  assign busy = (state == CHECK) || (state == EVAL);

endmodule
